spike_count_classifier: RTL and testbench



---
 rtl/spike_count_classifier.sv | 161 ++++++++++++++++
 tb/tb_spike_count_classifier.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spike_count_classifier.sv
// Windowed spike counter with sequential argmax and a valid/ready label output.
// Optional tie flag output enabled by defining SPIKE_CLASSIFIER_TIE_FLAG_EN.
module spike_count_classifier #(
    parameter int unsigned NUM_CLASSES = 2,
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned TIME_UNITS  = 15,
    parameter int unsigned LABEL_W     = 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic [NUM_CLASSES-1:0]         spk_in,
    output logic                           busy,
    output logic [LABEL_W-1:0]             label_out,
    output logic                           label_valid,
    input  logic                           label_ready,
    output logic [NUM_CLASSES*CNT_W-1:0]   counts_out
`ifdef SPIKE_CLASSIFIER_TIE_FLAG_EN
    ,
    output logic                           tie_out
`endif
);

    localparam int unsigned WIN_W = (TIME_UNITS > 1) ? $clog2(TIME_UNITS) : 1;
    localparam int unsigned IDX_W = $clog2(NUM_CLASSES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_COUNT,
        S_DECIDE,
        S_OUT
    } state_t;

    state_t                              state_q, state_d;
    logic [NUM_CLASSES-1:0][CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIN_W-1:0]                    win_q, win_d;
    logic [IDX_W-1:0]                    idx_q, idx_d;
    logic [LABEL_W-1:0]                  best_q, best_d;
    logic [LABEL_W-1:0]                  label_q, label_d;
    logic                                busy_q, busy_d;
    logic                                valid_q, valid_d;
    logic [LABEL_W-1:0]                  cmp_k;
`ifdef SPIKE_CLASSIFIER_TIE_FLAG_EN
    logic                                tie_q, tie_d;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            win_q   <= '0;
            idx_q   <= '0;
            best_q  <= '0;
            label_q <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
`ifdef SPIKE_CLASSIFIER_TIE_FLAG_EN
            tie_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            win_q   <= win_d;
            idx_q   <= idx_d;
            best_q  <= best_d;
            label_q <= label_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
`ifdef SPIKE_CLASSIFIER_TIE_FLAG_EN
            tie_q   <= tie_d;
`endif
        end
    end

    assign cmp_k = LABEL_W'(idx_q);

    // Next-state, counting and argmax; DECIDE spends one extra edge latching the winner.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        win_d   = win_q;
        idx_d   = idx_q;
        best_d  = best_q;
        label_d = label_q;
`ifdef SPIKE_CLASSIFIER_TIE_FLAG_EN
        tie_d   = tie_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    cnt_d   = '0;
                    win_d   = '0;
                    state_d = S_COUNT;
                end
            end
            S_COUNT: begin
                for (int i = 0; i < int'(NUM_CLASSES); i++) begin
                    if (spk_in[i] && (cnt_q[i] != CNT_MAX)) begin
                        cnt_d[i] = cnt_q[i] + CNT_W'(1);
                    end
                end
                if (win_q == WIN_W'(TIME_UNITS - 1)) begin
                    win_d   = '0;
                    idx_d   = IDX_W'(1);
                    best_d  = '0;
`ifdef SPIKE_CLASSIFIER_TIE_FLAG_EN
                    tie_d   = 1'b0;
`endif
                    state_d = S_DECIDE;
                end else begin
                    win_d = win_q + WIN_W'(1);
                end
            end
            S_DECIDE: begin
                if (idx_q == IDX_W'(NUM_CLASSES)) begin
                    label_d = best_q;
                    idx_d   = '0;
                    state_d = S_OUT;
                end else begin
                    // Strict compare keeps the lowest index on ties.
                    if (cnt_q[cmp_k] > cnt_q[best_q]) begin
                        best_d = cmp_k;
`ifdef SPIKE_CLASSIFIER_TIE_FLAG_EN
                        tie_d  = 1'b0;
`endif
                    end
`ifdef SPIKE_CLASSIFIER_TIE_FLAG_EN
                    else if (cnt_q[cmp_k] == cnt_q[best_q]) begin
                        tie_d = 1'b1;
                    end
`endif
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            S_OUT: begin
                if (label_ready) begin
                    if (start) begin
                        cnt_d   = '0;
                        win_d   = '0;
                        state_d = S_COUNT;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d  = (state_d != S_IDLE);
        valid_d = (state_d == S_OUT);
    end

    assign busy        = busy_q;
    assign label_valid = valid_q;
    assign label_out   = label_q;
    assign counts_out  = cnt_q;
`ifdef SPIKE_CLASSIFIER_TIE_FLAG_EN
    assign tie_out     = tie_q;
`endif

endmodule

// File: tb/tb_spike_count_classifier.sv
// Self-checking bench: two lockstep instances (8-bit and 3-bit counters) against a window-sum/argmax model.
module tb_spike_count_classifier;

    localparam int unsigned NC  = 2;
    localparam int unsigned TU  = 15;
    localparam int unsigned CW  = 8;
    localparam int unsigned CWS = 3;
    localparam int unsigned LAT = TU + NC;

    typedef logic [NC-1:0] vec_t;

    logic            clk = 1'b0;
    logic            reset;
    logic            start;
    logic            label_ready;
    vec_t            spk_in;
    logic            busy_a, valid_a, busy_b, valid_b;
    logic [0:0]      label_a, label_b;
    logic [NC*CW-1:0]  counts_a;
    logic [NC*CWS-1:0] counts_b;
`ifdef SPIKE_CLASSIFIER_TIE_FLAG_EN
    logic            tie_a, tie_b;
`endif

    int tests = 0;
    int fails = 0;
    vec_t win[$];
    logic [31:0] exp_lbl_a, exp_cnt_a, exp_lbl_b, exp_cnt_b;

    always #5 clk = ~clk;

    spike_count_classifier #(.NUM_CLASSES(NC), .CNT_W(CW), .TIME_UNITS(TU), .LABEL_W(1)) dut_a (
        .clk(clk), .reset(reset), .start(start), .spk_in(spk_in), .busy(busy_a),
        .label_out(label_a), .label_valid(valid_a), .label_ready(label_ready), .counts_out(counts_a)
`ifdef SPIKE_CLASSIFIER_TIE_FLAG_EN
        , .tie_out(tie_a)
`endif
    );

    spike_count_classifier #(.NUM_CLASSES(NC), .CNT_W(CWS), .TIME_UNITS(TU), .LABEL_W(1)) dut_b (
        .clk(clk), .reset(reset), .start(start), .spk_in(spk_in), .busy(busy_b),
        .label_out(label_b), .label_valid(valid_b), .label_ready(label_ready), .counts_out(counts_b)
`ifdef SPIKE_CLASSIFIER_TIE_FLAG_EN
        , .tie_out(tie_b)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain saturating sums over the window, then first index of the maximum.
    task automatic model(input int cap, input int w, output logic [31:0] packed_cnt,
                         output logic [31:0] lbl, output logic tie);
        int c[NC];
        int mx;
        int nmx;
        foreach (c[i]) c[i] = 0;
        foreach (win[t]) begin
            for (int i = 0; i < int'(NC); i++) begin
                if (win[t][i] && c[i] < cap) c[i]++;
            end
        end
        mx = 0;
        foreach (c[i]) if (c[i] > mx) mx = c[i];
        lbl = 0;
        nmx = 0;
        for (int i = int'(NC) - 1; i >= 0; i--) begin
            if (c[i] == mx) begin
                lbl = 32'(i);
                nmx++;
            end
        end
        tie = (nmx >= 2);
        packed_cnt = 0;
        foreach (c[i]) packed_cnt = packed_cnt | (32'(c[i]) << (w * i));
    endtask

    task automatic check_result(input string tag);
        logic tie_a_exp, tie_b_exp;
        model((1 << CW) - 1, CW, exp_cnt_a, exp_lbl_a, tie_a_exp);
        model((1 << CWS) - 1, CWS, exp_cnt_b, exp_lbl_b, tie_b_exp);
        chk({tag, "_label_a"}, 32'(label_a), exp_lbl_a);
        chk({tag, "_counts_a"}, 32'(counts_a), exp_cnt_a);
        chk({tag, "_label_b"}, 32'(label_b), exp_lbl_b);
        chk({tag, "_counts_b"}, 32'(counts_b), exp_cnt_b);
        chk({tag, "_valid_b"}, 32'(valid_b), 32'd1);
`ifdef SPIKE_CLASSIFIER_TIE_FLAG_EN
        chk({tag, "_tie_a"}, 32'(tie_a), 32'(tie_a_exp));
        chk({tag, "_tie_b"}, 32'(tie_b), 32'(tie_b_exp));
`else
        if (tie_a_exp && tie_b_exp) begin end
`endif
    endtask

    task automatic begin_from_idle();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic feed(input int n);
        for (int t = 0; t < n; t++) begin
            spk_in = win[t];
            start  = 1'($urandom);
            tick();
        end
        start  = 1'b0;
        spk_in = vec_t'($urandom);
    endtask

    task automatic await_valid(input string tag, input int base);
        int n;
        n = base;
        while (!valid_a && n < 60) begin
            tick();
            n++;
        end
        chk({tag, "_latency"}, 32'(n), 32'(LAT));
    endtask

    task automatic hold(input string tag, input int cycles);
        label_ready = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            start  = 1'($urandom);
            spk_in = vec_t'($urandom);
            tick();
            chk({tag, "_hold_valid"}, 32'(valid_a), 32'd1);
            chk({tag, "_hold_label"}, 32'(label_a), exp_lbl_a);
            chk({tag, "_hold_counts"}, 32'(counts_a), exp_cnt_a);
            chk({tag, "_hold_busy"}, 32'(busy_a), 32'd1);
        end
        start = 1'b0;
    endtask

    task automatic handshake(input string tag);
        label_ready = 1'b1;
        start = 1'b0;
        tick();
        label_ready = 1'b0;
        chk({tag, "_hs_valid"}, 32'(valid_a), 32'd0);
        chk({tag, "_hs_busy"}, 32'(busy_a), 32'd0);
        chk({tag, "_idle_counts"}, 32'(counts_a), exp_cnt_a);
    endtask

    task automatic full_window(input string tag, input int ready_delay);
        begin_from_idle();
        chk({tag, "_busy"}, 32'(busy_a), 32'd1);
        chk({tag, "_cleared"}, 32'(counts_a), 32'd0);
        feed(int'(TU));
        await_valid(tag, int'(TU));
        check_result(tag);
        if (ready_delay > 0) hold(tag, ready_delay);
        handshake(tag);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        label_ready = 1'b0;
        spk_in = '0;
        #12;
        chk("rst_busy", 32'(busy_a), 32'd0);
        chk("rst_valid", 32'(valid_a), 32'd0);
        chk("rst_label", 32'(label_a), 32'd0);
        chk("rst_counts", 32'(counts_a), 32'd0);
        #2 reset = 1'b0;
        tick();

        // Class 1 wins
        win.delete();
        for (int t = 0; t < int'(TU); t++) win.push_back(2'b10);
        full_window("cls1", 0);

        // Alternating spikes, class 0 leads by one
        win.delete();
        for (int t = 0; t < int'(TU); t++) win.push_back((t % 2 == 0) ? 2'b01 : 2'b10);
        full_window("alt", 0);

        // Exact tie resolves to class 0
        win.delete();
        for (int t = 0; t < 14; t++) win.push_back(2'b11);
        win.push_back(2'b00);
        full_window("tie", 0);

        // Saturation on the 3-bit instance
        win.delete();
        for (int t = 0; t < int'(TU); t++) win.push_back((t % 3 == 0) ? 2'b11 : 2'b01);
        full_window("sat", 0);

        // Backpressure with ignored start pulses
        win.delete();
        for (int t = 0; t < int'(TU); t++) win.push_back(vec_t'($urandom));
        full_window("bp", 10);

        // Asynchronous reset mid-window, then a clean window
        win.delete();
        for (int t = 0; t < 7; t++) win.push_back(vec_t'($urandom));
        begin_from_idle();
        feed(7);
        model((1 << CW) - 1, CW, exp_cnt_a, exp_lbl_a, exp_lbl_b[0]);
        chk("live_counts", 32'(counts_a), exp_cnt_a);
        #3 reset = 1'b1;
        #1;
        chk("arst_busy", 32'(busy_a), 32'd0);
        chk("arst_valid", 32'(valid_a), 32'd0);
        chk("arst_counts", 32'(counts_a), 32'd0);
        chk("arst_counts_b", 32'(counts_b), 32'd0);
        #1 reset = 1'b0;
        tick();
        win.delete();
        for (int t = 0; t < int'(TU); t++) win.push_back(vec_t'($urandom));
        full_window("post_rst", 0);

        // Back-to-back windows with start and ready held high
        win.delete();
        for (int t = 0; t < int'(TU); t++) win.push_back(2'b01);
        spk_in = 2'b01;
        start = 1'b1;
        label_ready = 1'b1;
        for (int w = 0; w < 3; w++) begin
            int n;
            tick();
            chk("b2b_cleared", 32'(counts_a), 32'd0);
            n = 0;
            do begin
                tick();
                n++;
            end while (!valid_a && n < 60);
            chk("b2b_period", 32'(n), 32'(LAT));
            check_result("b2b");
        end
        start = 1'b0;
        tick();
        chk("b2b_end_busy", 32'(busy_a), 32'd0);
        chk("b2b_end_valid", 32'(valid_a), 32'd0);
        label_ready = 1'b0;

        // Random windows with random backpressure
        for (int r = 0; r < 8; r++) begin
            win.delete();
            for (int t = 0; t < int'(TU); t++) win.push_back(vec_t'($urandom));
            full_window("rand", int'($urandom_range(0, 4)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
